// File: rtl/mips_pkg.sv
// Shared constants and types for the MIPS front end: instruction field slices,
// reset defaults and the fetch state encoding.
package mips_pkg;

  localparam int unsigned OP_MSB    = 31;
  localparam int unsigned OP_LSB    = 26;
  localparam int unsigned FUNCT_MSB = 5;
  localparam int unsigned FUNCT_LSB = 0;

  localparam logic [31:0] NOP              = 32'h0000_0000;
  localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;

  typedef enum logic [0:0] {
    StRun,
    StDrain
  } fetch_state_e;

endpackage

// File: rtl/fetch_fifo.sv
// Small synchronous FIFO with flush and occupancy count; head is read
// combinationally, there is no write-to-read bypass.
module fetch_fifo #(
  parameter int unsigned Depth = 2,
  parameter int unsigned Width = 64
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     flush_i,
  input  logic                     push_i,
  input  logic [Width-1:0]         wdata_i,
  input  logic                     pop_i,
  output logic [Width-1:0]         rdata_o,
  output logic [$clog2(Depth):0]   count_o,
  output logic                     full_o,
  output logic                     empty_o
);

  localparam int unsigned AW = $clog2(Depth);

  logic [Width-1:0] mem_q [Depth];
  logic [AW-1:0]    wptr_q, wptr_d;
  logic [AW-1:0]    rptr_q, rptr_d;
  logic [AW:0]      cnt_q, cnt_d;
  logic             do_push, do_pop;

  assign empty_o = (cnt_q == '0);
  assign full_o  = (cnt_q == (AW+1)'(Depth));
  assign count_o = cnt_q;
  assign rdata_o = mem_q[rptr_q];

  // A push into a full FIFO is only taken when the head leaves in the same cycle.
  assign do_pop  = pop_i && !empty_o;
  assign do_push = push_i && (!full_o || do_pop);

  always_comb begin
    wptr_d = wptr_q;
    rptr_d = rptr_q;
    cnt_d  = cnt_q;
    if (flush_i) begin
      wptr_d = '0;
      rptr_d = '0;
      cnt_d  = '0;
    end else begin
      if (do_push) wptr_d = wptr_q + AW'(1);
      if (do_pop)  rptr_d = rptr_q + AW'(1);
      cnt_d = cnt_q + (AW+1)'(do_push) - (AW+1)'(do_pop);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wptr_q <= '0;
      rptr_q <= '0;
      cnt_q  <= '0;
    end else begin
      wptr_q <= wptr_d;
      rptr_q <= rptr_d;
      cnt_q  <= cnt_d;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push && !flush_i) mem_q[wptr_q] <= wdata_i;
  end

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch stage: owns the PC, issues word reads to instruction memory,
// buffers returned words with their PCs and flushes/redirects on taken branches.
module fetch_unit
  import mips_pkg::*;
#(
  parameter logic [31:0] RESET_PC = DEFAULT_RESET_PC,
  parameter int unsigned DEPTH    = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic        imem_req_valid,
  input  logic        imem_req_ready,
  output logic [31:0] imem_req_addr,
  input  logic        imem_rsp_valid,
  input  logic [31:0] imem_rsp_data,
  output logic        if_valid,
  input  logic        if_ready,
  output logic [31:0] if_instr,
  output logic [5:0]  if_op,
  output logic [5:0]  if_funct,
  output logic [31:0] if_pc,
  output logic [31:0] if_pc_plus4,
  input  logic        redir_valid,
  input  logic [31:0] redir_pc
);

  localparam int unsigned CW = $clog2(DEPTH) + 1;

  fetch_state_e  state_q, state_d;
  logic [31:0]   pc_q, pc_d;
  logic [CW-1:0] out_q, out_d;
  logic [CW-1:0] stale_q, stale_d;
  logic [CW-1:0] drain_total;
  logic          en_q;

  logic [CW-1:0] buf_count, tag_count;
  logic          buf_full, buf_empty, tag_full, tag_empty;
  logic [63:0]   buf_rdata;
  logic [31:0]   tag_rdata;
  logic [CW:0]   inflight;
  logic          req_fire, rsp_live, buf_push, buf_pop;

  assign inflight       = {1'b0, buf_count} + {1'b0, out_q};
  // en_q keeps the request channel quiet while reset is asserted.
  assign imem_req_valid = en_q && (state_q == StRun) && (inflight < (CW+1)'(DEPTH)) &&
                          !redir_valid;
  assign imem_req_addr  = pc_q;
  assign req_fire       = imem_req_valid && imem_req_ready;

  assign rsp_live = imem_rsp_valid && (state_q == StRun) && (out_q != '0);
  assign buf_push = rsp_live && !redir_valid;
  assign if_valid = !buf_empty;
  assign buf_pop  = if_valid && if_ready && !redir_valid;

  assign if_instr    = if_valid ? buf_rdata[31:0] : NOP;
  assign if_pc       = if_valid ? buf_rdata[63:32] : '0;
  assign if_op       = if_instr[OP_MSB:OP_LSB];
  assign if_funct    = if_instr[FUNCT_MSB:FUNCT_LSB];
  assign if_pc_plus4 = if_valid ? (if_pc + 32'd4) : '0;

  fetch_fifo #(
    .Depth (DEPTH),
    .Width (64)
  ) u_buf (
    .clk     (clk),
    .rst_n   (rst_n),
    .flush_i (redir_valid),
    .push_i  (buf_push),
    .wdata_i ({tag_rdata, imem_rsp_data}),
    .pop_i   (buf_pop),
    .rdata_o (buf_rdata),
    .count_o (buf_count),
    .full_o  (buf_full),
    .empty_o (buf_empty)
  );

  // Address tags of outstanding requests, consumed in order as responses land.
  fetch_fifo #(
    .Depth (DEPTH),
    .Width (32)
  ) u_tag (
    .clk     (clk),
    .rst_n   (rst_n),
    .flush_i (redir_valid),
    .push_i  (req_fire),
    .wdata_i (pc_q),
    .pop_i   (buf_push),
    .rdata_o (tag_rdata),
    .count_o (tag_count),
    .full_o  (tag_full),
    .empty_o (tag_empty)
  );

  always_comb begin
    state_d     = state_q;
    pc_d        = pc_q;
    out_d       = out_q;
    stale_d     = stale_q;
    drain_total = stale_q + out_q;
    if (redir_valid) begin
      // Everything still in flight becomes stale; a response landing now is one fewer.
      if (imem_rsp_valid && (drain_total != '0)) drain_total = drain_total - CW'(1);
      pc_d    = redir_pc & 32'hFFFF_FFFC;
      out_d   = '0;
      stale_d = drain_total;
      state_d = (drain_total != '0) ? StDrain : StRun;
    end else if (state_q == StDrain) begin
      if (imem_rsp_valid) begin
        stale_d = stale_q - CW'(1);
        if (stale_q == CW'(1)) state_d = StRun;
      end
    end else begin
      if (req_fire) pc_d = pc_q + 32'd4;
      out_d = out_q + CW'(req_fire) - CW'(rsp_live);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StRun;
      pc_q    <= RESET_PC;
      out_q   <= '0;
      stale_q <= '0;
      en_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      out_q   <= out_d;
      stale_q <= stale_d;
      en_q    <= 1'b1;
    end
  end

  a_no_overflow : assert property (@(posedge clk) disable iff (!rst_n)
    !(imem_rsp_valid && (state_q == StRun) && (out_q == '0)));
  a_tag_room : assert property (@(posedge clk) disable iff (!rst_n)
    !(req_fire && tag_full));
  a_tag_avail : assert property (@(posedge clk) disable iff (!rst_n)
    !(buf_push && tag_empty));
  a_buf_room : assert property (@(posedge clk) disable iff (!rst_n)
    !(buf_push && buf_full && !buf_pop));
  a_tag_count : assert property (@(posedge clk) disable iff (!rst_n)
    (state_q != StRun) || (tag_count == out_q));

endmodule

// File: tb/tb_fetch_unit.sv
// Randomised scoreboard bench for fetch_unit with an in-order, variable-latency
// instruction memory model and an epoch-based model of redirect squashing.
module tb_fetch_unit;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        imem_req_valid, imem_req_ready;
  logic [31:0] imem_req_addr;
  logic        imem_rsp_valid;
  logic [31:0] imem_rsp_data;
  logic        if_valid, if_ready;
  logic [31:0] if_instr, if_pc, if_pc_plus4;
  logic [5:0]  if_op, if_funct;
  logic        redir_valid;
  logic [31:0] redir_pc;

  always #5 clk = ~clk;

  fetch_unit #(
    .RESET_PC (32'h0000_0000),
    .DEPTH    (2)
  ) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .imem_req_valid (imem_req_valid),
    .imem_req_ready (imem_req_ready),
    .imem_req_addr  (imem_req_addr),
    .imem_rsp_valid (imem_rsp_valid),
    .imem_rsp_data  (imem_rsp_data),
    .if_valid       (if_valid),
    .if_ready       (if_ready),
    .if_instr       (if_instr),
    .if_op          (if_op),
    .if_funct       (if_funct),
    .if_pc          (if_pc),
    .if_pc_plus4    (if_pc_plus4),
    .redir_valid    (redir_valid),
    .redir_pc       (redir_pc)
  );

  typedef struct {logic [31:0] addr; int epoch; int rdy;} req_t;
  typedef struct {logic [31:0] pc; logic [31:0] instr;} exp_t;

  req_t        pend[$];
  exp_t        expq[$];
  int          checks = 0, failures = 0;
  int          epoch = 0, cyc = 0;
  logic [31:0] model_pc = 32'h0;
  int          p_ifready = 100, p_reqready = 100, p_redir = 0, p_rsp = 100, max_lat = 1;
  bit          force_redir = 0;
  logic [31:0] force_target = 32'h0;
  bit          running = 0;
  int          n_accept = 0, first_acc_cyc = -1, first_val_cyc = -1;
  logic [31:0] last_acc_addr = 32'h1;
  bit          saw_wrap = 0;
  logic        redir_prev = 1'b0;
  exp_t        mon_e;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%h required=%h (t=%0t)", name, act, req, $time);
    end
  endtask

  function automatic logic [31:0] pick_target();
    case ($urandom_range(2))
      0:       return 32'h0000_0103;
      1:       return 32'hFFFF_FFF9;
      default: return $urandom;
    endcase
  endfunction

  task automatic drive_cycle();
    bit          do_redir;
    logic [31:0] tgt, data;
    req_t        r;
    if_ready       = ($urandom_range(99) < p_ifready);
    imem_req_ready = ($urandom_range(99) < p_reqready);
    do_redir       = force_redir || ($urandom_range(99) < p_redir);
    tgt            = force_redir ? force_target : pick_target();
    force_redir    = 0;
    imem_rsp_valid = 1'b0;
    imem_rsp_data  = $urandom;
    if (pend.size() > 0 && pend[0].rdy <= cyc && $urandom_range(99) < p_rsp) begin
      r    = pend.pop_front();
      data = ($urandom_range(3) == 0) ? 32'h0043_0820 : $urandom;
      imem_rsp_valid = 1'b1;
      imem_rsp_data  = data;
      // Only responses for the current epoch and not squashed this cycle reach decode.
      if (r.epoch == epoch && !do_redir) expq.push_back('{pc: r.addr, instr: data});
    end
    redir_valid = do_redir;
    redir_pc    = tgt;
    if (do_redir) begin
      epoch++;
      expq.delete();
      model_pc = tgt & 32'hFFFF_FFFC;
    end
  endtask

  initial begin
    forever begin
      @(posedge clk);
      cyc++;
      if (running) begin
        #1;
        drive_cycle();
      end
    end
  end

  // Monitor: request address check, memory bookkeeping and decode-side scoreboard.
  always @(negedge clk) begin
    if (!rst_n) begin
      redir_prev <= 1'b0;
    end else begin
      if (redir_prev) chk("if_valid_after_redir", {31'b0, if_valid}, 32'h0);
      if (imem_req_valid) begin
        chk("req_addr", imem_req_addr, model_pc);
        if (imem_req_ready) begin
          pend.push_back('{addr: model_pc, epoch: epoch,
                           rdy: cyc + int'($urandom_range(max_lat, 1))});
          if (last_acc_addr == 32'hFFFF_FFFC && model_pc == 32'h0) saw_wrap = 1;
          last_acc_addr = model_pc;
          if (first_acc_cyc < 0) first_acc_cyc = cyc;
          n_accept++;
          model_pc = model_pc + 32'd4;
        end
      end
      if (if_valid && first_val_cyc < 0) first_val_cyc = cyc;
      if (if_valid && if_ready && !redir_valid) begin
        if (expq.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL pop_unexpected actual pc=%h required none", if_pc);
        end else begin
          mon_e = expq.pop_front();
          chk("if_pc", if_pc, mon_e.pc);
          chk("if_instr", if_instr, mon_e.instr);
          chk("if_op", {26'b0, if_op}, {26'b0, mon_e.instr[31:26]});
          chk("if_funct", {26'b0, if_funct}, {26'b0, mon_e.instr[5:0]});
          chk("if_pc_plus4", if_pc_plus4, mon_e.pc + 32'd4);
        end
      end
      redir_prev <= redir_valid;
    end
  end

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_req_valid"}, {31'b0, imem_req_valid}, 32'h0);
    chk({tag, "_req_addr"}, imem_req_addr, 32'h0);
    chk({tag, "_if_valid"}, {31'b0, if_valid}, 32'h0);
    chk({tag, "_if_instr"}, if_instr, 32'h0);
    chk({tag, "_if_pc"}, if_pc, 32'h0);
    chk({tag, "_if_pc_plus4"}, if_pc_plus4, 32'h0);
    chk({tag, "_if_op_funct"}, {20'b0, if_op, if_funct}, 32'h0);
  endtask

  task automatic drain_and_check(input string tag);
    p_redir = 0; p_reqready = 0; p_ifready = 100; p_rsp = 100;
    for (int i = 0; i < 200 && (pend.size() != 0 || expq.size() != 0); i++) @(posedge clk);
    @(posedge clk); #2;
    chk({tag, "_pending_left"}, pend.size() + expq.size(), 32'h0);
    chk({tag, "_if_valid_idle"}, {31'b0, if_valid}, 32'h0);
  endtask

  initial begin
    int a0;
    rst_n = 1'b0;
    imem_req_ready = 0; imem_rsp_valid = 0; imem_rsp_data = 0;
    if_ready = 0; redir_valid = 0; redir_pc = 0;
    repeat (3) @(posedge clk);
    #1;
    check_reset_outputs("reset");
    rst_n = 1'b1;
    running = 1;

    // Streaming with single-cycle memory.
    repeat (30) @(posedge clk);
    chk("first_valid_latency", first_val_cyc - first_acc_cyc, 32'd2);

    // Decode stalled: exactly two fetches issue, then resume at the next PC.
    p_ifready = 0;
    force_target = 32'h0000_0200; force_redir = 1;
    @(posedge clk); #2;
    a0 = n_accept;
    repeat (15) @(posedge clk);
    chk("stall_accepts", n_accept - a0, 32'd2);
    p_ifready = 100;
    repeat (10) @(posedge clk);

    // Redirect with fetches outstanding on a slow memory.
    max_lat = 4;
    repeat (5) @(posedge clk);
    force_target = 32'h0000_0103; force_redir = 1;
    repeat (25) @(posedge clk);

    // PC wrap across the top of the address space.
    max_lat = 1;
    force_target = 32'hFFFF_FFF9; force_redir = 1;
    repeat (20) @(posedge clk);
    chk("pc_wrap_seen", {31'b0, saw_wrap}, 32'h1);

    // Random traffic with redirects, stalls and variable latency.
    p_redir = 8; max_lat = 3; p_ifready = 70; p_reqready = 70; p_rsp = 75;
    repeat (2000) @(posedge clk);
    drain_and_check("drain1");

    // Asynchronous reset mid-stream.
    p_reqready = 100; p_ifready = 50; max_lat = 2;
    repeat (7) @(posedge clk);
    #3;
    running = 0;
    rst_n = 1'b0;
    imem_rsp_valid = 0; redir_valid = 0; if_ready = 0; imem_req_ready = 0;
    #1;
    check_reset_outputs("midreset");
    pend.delete(); expq.delete(); epoch++; model_pc = 32'h0; last_acc_addr = 32'h1;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    running = 1;
    p_ifready = 100; p_reqready = 100; p_rsp = 100;
    a0 = n_accept;
    repeat (20) @(posedge clk);
    checks++;
    if (n_accept - a0 < 5) begin
      failures++;
      $display("FAIL post_reset_progress actual=%0d required>=5", n_accept - a0);
    end
    drain_and_check("drain2");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
